// File: rtl/obstacle_pkg.sv
// obstacle_pkg: shared FSM state, slot record, grid sizes and cell-geometry helpers
package obstacle_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;
   typedef struct packed {
      logic [4:0] col;
      logic [4:0] row;
      logic       valid;
      logic       move;
   } slot_t;
   localparam int GRID_COLS = 32;
   localparam int GRID_ROWS = 24;
   function automatic logic [10:0] cell_org(input logic [4:0] idx, input int size);
      return 11'(1 + int'(idx) * size);
   endfunction
   function automatic logic in_span(input logic [9:0] p, input logic [10:0] org, input int size);
      return ({1'b0, p} >= org) && ({1'b0, p} < org + 11'(size));
   endfunction
endpackage

// File: rtl/obstacle_level_rom.sv
// obstacle_level_rom: combinational level table addressed by {level[2:0], slot[4:0]}
module obstacle_level_rom
   import obstacle_pkg::*;
(
   input  logic [7:0] i_addr,
   output slot_t      o_slot
);
   logic [1:0] w_lvl;
   logic [4:0] w_s;
   assign w_lvl = i_addr[6:5];
   assign w_s   = i_addr[4:0];
   // levels 0..3 are base layouts; levels 4..7 are their vertical mirrors
   always_comb begin
      o_slot = '0;
      if (w_lvl == 2'd0 && w_s < 5'd16)
         o_slot = '{col: 5'd11 + {2'b0, w_s[2:0]}, row: w_s[3] ? 5'd19 : 5'd5, valid: 1'b1, move: 1'b0};
      else if (w_lvl == 2'd1 && w_s < 5'd4)
         o_slot = '{col: w_s == 5'd0 ? 5'd31 : w_s == 5'd1 ? 5'd0 : w_s == 5'd2 ? 5'd15 : 5'd30,
                    row: w_s == 5'd0 ? 5'd2 : w_s == 5'd1 ? 5'd10 : w_s == 5'd2 ? 5'd12 : 5'd23,
                    valid: 1'b1, move: ~w_s[0]};
      else if (w_lvl == 2'd2 && w_s < 5'd24)
         o_slot = '{col: w_s, row: w_s, valid: 1'b1, move: w_s[0]};
      else if (w_lvl == 2'd3)
         o_slot = '{col: {w_s[3:0], w_s[4]}, row: w_s[4] ? 5'd23 : 5'd0, valid: 1'b1, move: 1'b0};
      if (i_addr[7])
         o_slot.row = 5'd23 - o_slot.row;
   end
endmodule

// File: rtl/obstacle_engine.sv
// obstacle_engine: loads obstacle levels from ROM, drives the VGA obstacle region and the sticky crash flag.
// Define OBSTACLE_MOVE_EN to let move_tick shift moving obstacles one column right (wrapping 31 -> 0).
module obstacle_engine
   import obstacle_pkg::*;
#(
   parameter int NUM_OBS    = 16,
   parameter int NUM_LEVELS = 4,
   parameter int CELL_W     = 20,
   parameter int CELL_H     = 16
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          en,
   input  logic                          load,
   input  logic [$clog2(NUM_LEVELS)-1:0] level_sel,
   input  logic [9:0]                    snake_head_x,
   input  logic [9:0]                    snake_head_y,
   input  logic                          head_valid,
   input  logic                          move_tick,
   input  logic                          crash_clr,
   input  logic [9:0]                    pixel_x,
   input  logic [9:0]                    pixel_y,
   output logic                          obstacle_region,
   output logic                          crashed,
   output logic                          busy
);
   localparam int LW = $clog2(NUM_LEVELS);
   localparam int SW = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;

   state_t             r_state;
   logic [LW-1:0]      r_level;
   logic [SW-1:0]      r_idx;
   logic               r_busy;
   logic               r_region;
   logic               r_crashed;
   logic [4:0]         r_col [NUM_OBS];
   logic [4:0]         r_row [NUM_OBS];
   logic [NUM_OBS-1:0] r_valid;
   slot_t              w_rom;
   logic               w_active;
   logic               w_load_acc;
   logic               w_last;
   logic               w_hit;
   logic               w_head_hit;

`ifdef OBSTACLE_MOVE_EN
   logic [NUM_OBS-1:0] r_move;
`else
   logic [1:0]         w_unused_move;
   assign w_unused_move = {w_rom.move, move_tick};
`endif

   assign w_active        = r_state == ACTIVE;
   assign w_load_acc      = load && r_state != LOAD;
   assign w_last          = r_idx == SW'(NUM_OBS - 1);
   assign obstacle_region = r_region;
   assign crashed         = r_crashed;
   assign busy            = r_busy;

   obstacle_level_rom u_rom (
      .i_addr ({3'(r_level), 5'(r_idx)}),
      .o_slot (w_rom)
   );

   // level-load sequencer: one slot per LOAD cycle; busy mirrors the LOAD state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_level <= '0;
         r_idx   <= '0;
         r_busy  <= 1'b0;
      end else if (r_state == LOAD) begin
         r_idx <= r_idx + 1'b1;
         if (w_last) begin
            r_state <= ACTIVE;
            r_busy  <= 1'b0;
         end
      end else if (load) begin
         r_state <= LOAD;
         r_level <= level_sel;
         r_idx   <= '0;
         r_busy  <= 1'b1;
      end
   end

   // slot table: written from ROM during LOAD, optionally shifted by move_tick in ACTIVE
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= '0;
      end else if (r_state == LOAD) begin
         r_col[r_idx]   <= w_rom.col;
         r_row[r_idx]   <= w_rom.row;
         r_valid[r_idx] <= w_rom.valid;
`ifdef OBSTACLE_MOVE_EN
         r_move[r_idx]  <= w_rom.move;
      end else if (w_active && move_tick) begin
         for (int i = 0; i < NUM_OBS; i++)
            if (r_move[i]) r_col[i] <= r_col[i] + 5'd1;
`endif
      end
   end

   // geometry match of the scan pixel and the head origin against every valid slot
   always_comb begin
      w_hit      = 1'b0;
      w_head_hit = 1'b0;
      for (int i = 0; i < NUM_OBS; i++) begin
         w_hit = w_hit | (r_valid[i]
                 && in_span(pixel_x, cell_org(r_col[i], CELL_W), CELL_W)
                 && in_span(pixel_y, cell_org(r_row[i], CELL_H), CELL_H));
         w_head_hit = w_head_hit | (r_valid[i]
                 && {1'b0, snake_head_x} == cell_org(r_col[i], CELL_W)
                 && {1'b0, snake_head_y} == cell_org(r_row[i], CELL_H));
      end
   end

   // registered region output and sticky crash flag (an accepted load clears, a hit beats crash_clr)
   always_ff @(posedge clk) begin
      if (reset) begin
         r_region  <= 1'b0;
         r_crashed <= 1'b0;
      end else begin
         r_region  <= en && w_active && w_hit;
         r_crashed <= w_load_acc ? 1'b0
                    : (head_valid && en && w_active && w_head_hit) ? 1'b1
                    : crash_clr ? 1'b0 : r_crashed;
      end
   end
endmodule

// File: tb/tb_obstacle_engine.sv
// tb_obstacle_engine: directed and randomized checks of obstacle_engine against a geometric reference model
module tb_obstacle_engine;
   logic       clk = 1'b0;
   logic       reset, en, load, head_valid, move_tick, crash_clr;
   logic [1:0] level_sel;
   logic [9:0] hx, hy, px, py;
   logic       region, crashed, busy;
   int         total = 0;
   int         bad = 0;
   int         ox[$], oy[$];
   bit         omv[$];
   int         busy_left = 0;
   bit         m_active = 0, m_crashed = 0, m_region = 0;
   int         n;

   always #5 clk = ~clk;

   obstacle_engine dut (
      .clk(clk), .reset(reset), .en(en), .load(load), .level_sel(level_sel),
      .snake_head_x(hx), .snake_head_y(hy), .head_valid(head_valid),
      .move_tick(move_tick), .crash_clr(crash_clr), .pixel_x(px), .pixel_y(py),
      .obstacle_region(region), .crashed(crashed), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic add_obs(input int col, input int row, input bit mv);
      ox.push_back(1 + col * 20);
      oy.push_back(1 + row * 16);
      omv.push_back(mv);
   endtask

   task automatic level_origins(input int lvl);
      ox.delete(); oy.delete(); omv.delete();
      if (lvl == 0)
         for (int c = 11; c <= 18; c++) begin
            add_obs(c, 5, 0);
            add_obs(c, 19, 0);
         end
`ifdef OBSTACLE_MOVE_EN
      if (lvl == 1) begin
         add_obs(31, 2, 1);
         add_obs(0, 10, 0);
         add_obs(15, 12, 1);
         add_obs(30, 23, 0);
      end
`endif
   endtask

   function automatic bit inside_any(input int x, input int y);
      foreach (ox[i])
         if (x >= ox[i] && x < ox[i] + 20 && y >= oy[i] && y < oy[i] + 16) return 1;
      return 0;
   endfunction

   function automatic bit head_any(input int x, input int y);
      foreach (ox[i])
         if (x == ox[i] && y == oy[i]) return 1;
      return 0;
   endfunction

   task automatic model_step();
      bit acc;
      if (reset) begin
         busy_left = 0; m_active = 0; m_crashed = 0; m_region = 0;
         ox.delete(); oy.delete(); omv.delete();
      end else begin
         acc = load && busy_left == 0;
         m_region = en && m_active && inside_any(int'(px), int'(py));
         m_crashed = acc ? 1'b0
                   : (head_valid && en && m_active && head_any(int'(hx), int'(hy))) ? 1'b1
                   : crash_clr ? 1'b0 : m_crashed;
`ifdef OBSTACLE_MOVE_EN
         if (m_active && move_tick)
            foreach (ox[i])
               if (omv[i]) ox[i] = 1 + ((((ox[i] - 1) / 20) + 1) % 32) * 20;
`endif
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) m_active = 1;
         end else if (load) begin
            busy_left = 16;
            m_active = 0;
            level_origins(int'(level_sel));
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("busy", busy, busy_left > 0);
      check("region", region, m_region);
      check("crashed", crashed, m_crashed);
   endtask

   task automatic idle_inputs();
      reset = 0; en = 1; load = 0; head_valid = 0; move_tick = 0; crash_clr = 0;
   endtask

   task automatic load_and_wait(input int lvl);
      level_sel = 2'(lvl); load = 1; tick(); load = 0;
      for (int k = 0; k < 40 && busy; k++) tick();
      check("load_done", busy, 0);
   endtask

   task automatic pix(input string tag, input int x, input int y, input bit exp);
      px = 10'(x); py = 10'(y); tick();
      check(tag, region, exp);
   endtask

   initial begin
      idle_inputs();
      reset = 1; level_sel = 0; hx = 0; hy = 0; px = 0; py = 0;
      tick(); tick();
      check("rst_busy", busy, 0);
      check("rst_region", region, 0);
      check("rst_crashed", crashed, 0);
      reset = 0;
      // level 0 load: busy for exactly 16 cycles
      level_sel = 0; load = 1; tick(); load = 0;
      n = busy ? 1 : 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (!busy) break;
         n++;
      end
      check("busy_len", n, 16);
      pix("px_221_81", 221, 81, 1);
      pix("px_220_81", 220, 81, 0);
      pix("px_380_96", 380, 96, 1);
      pix("px_381_96", 381, 96, 0);
      pix("px_361_305", 361, 305, 1);
      pix("px_361_321", 361, 321, 0);
      en = 0; pix("px_en_off", 221, 81, 0); en = 1;
      // collisions
      hx = 281; hy = 289; head_valid = 1; tick(); head_valid = 0;
      check("head_miss", crashed, 0);
      hx = 281; hy = 305; head_valid = 1; tick(); head_valid = 0;
      check("head_hit", crashed, 1);
      tick();
      check("crash_sticky", crashed, 1);
      crash_clr = 1; tick(); crash_clr = 0;
      check("crash_clr", crashed, 0);
      head_valid = 1; crash_clr = 1; tick(); head_valid = 0; crash_clr = 0;
      check("set_beats_clr", crashed, 1);
      crash_clr = 1; tick(); crash_clr = 0;
      // load pulse at cycle 5 of a load is ignored and keeps level 0
      load = 1; tick(); load = 0;
      n = 1;
      for (int k = 0; k < 40; k++) begin
         if (n == 5) begin load = 1; level_sel = 1; end
         tick();
         load = 0; level_sel = 0;
         if (!busy) break;
         n++;
      end
      check("busy_len_ignore", n, 16);
      pix("ignored_lvl", 221, 81, 1);
      // reset at cycle 8 of a load aborts it
      load = 1; tick(); load = 0;
      for (int k = 1; k < 8; k++) tick();
      reset = 1; tick(); reset = 0;
      check("abort_busy", busy, 0);
      pix("abort_region", 221, 81, 0);
      for (int k = 0; k < 20; k++) tick();
      check("abort_idle", busy, 0);
      pix("abort_region2", 361, 305, 0);
      hx = 281; hy = 305; head_valid = 1; tick(); head_valid = 0;
      check("idle_no_crash", crashed, 0);
`ifdef OBSTACLE_MOVE_EN
      load_and_wait(1);
      pix("mv_before", 621, 33, 1);
      move_tick = 1; tick(); move_tick = 0;
      pix("mv_wrap_x1", 1, 33, 1);
      pix("mv_old_x", 621, 33, 0);
`endif
      // randomized traffic on level 0
      load_and_wait(0);
      for (int k = 0; k < 4000; k++) begin
         reset      = $urandom % 700 == 0;
         en         = $urandom % 8 != 0;
         load       = $urandom % 150 == 0;
         level_sel  = 0;
         head_valid = $urandom % 4 == 0;
         crash_clr  = $urandom % 10 == 0;
         move_tick  = $urandom % 5 == 0;
         if ($urandom % 2 == 1) begin
            hx = 10'(1 + (11 + $urandom_range(0, 7)) * 20);
            hy = 10'(1 + ($urandom % 2 == 1 ? 19 : 5) * 16);
         end else begin
            hx = 10'($urandom_range(200, 400));
            hy = 10'($urandom_range(60, 340));
         end
         if ($urandom % 4 != 0) begin
            px = 10'($urandom_range(210, 390));
            py = 10'($urandom % 2 == 1 ? $urandom_range(70, 105) : $urandom_range(295, 330));
         end else begin
            px = 10'($urandom % 640);
            py = 10'($urandom % 480);
         end
         tick();
      end
      idle_inputs();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/obstacle_engine.md
OBSTACLE_ENGINE -- requirements
Module: obstacle_engine

Interface
REQ-001 SHALL have parameter NUM_OBS, default 16: obstacle slots per level, 1..32.
REQ-002 SHALL have parameter NUM_LEVELS, default 4: levels held in ROM, power of two, 2..8.
REQ-003 SHALL have parameter CELL_W, default 20: cell width, pixels.
REQ-004 SHALL have parameter CELL_H, default 16: cell height, pixels.
REQ-005 SHALL have port clk  in  1: single clock. All logic is clocked on the rising edge.
REQ-006 SHALL have port reset  in  1: synchronous, active-high.
REQ-007 SHALL have port en  in  1: enables region output and collision checks.
REQ-008 SHALL have port load  in  1: single-cycle pulse that starts a level load.
REQ-009 SHALL have port level_sel  in  $clog2(NUM_LEVELS): level to load, sampled in the load cycle.
REQ-010 SHALL have port snake_head_x / snake_head_y  in  10 each: pixel origin of the head cell.
REQ-011 SHALL have port head_valid  in  1: single-cycle pulse; the head position is new.
REQ-012 SHALL have port move_tick  in  1: obstacle motion strobe.
REQ-013 SHALL have port crash_clr  in  1: clears crashed.
REQ-014 SHALL have port pixel_x / pixel_y  in  10 each: VGA scan position.
REQ-015 SHALL have port obstacle_region  out  1: the registered pixel is inside an obstacle.
REQ-016 SHALL have port crashed  out  1: sticky collision flag.
REQ-017 SHALL have port busy  out  1: high while state is LOAD.

Function
REQ-018 SHALL hold per slot: col[4:0], row[4:0], valid, move.
- Pixel origin: x = 1 + col*CELL_W, y = 1 + row*CELL_H.
REQ-019 SHALL use FSM states IDLE, LOAD, ACTIVE.
- IDLE -(load)-> LOAD -(last slot written)-> ACTIVE -(load)-> LOAD.
REQ-020 SHALL, in LOAD:
- write slot i from ROM[level, i] in cycle i, i = 0..NUM_OBS-1;
- take exactly NUM_OBS cycles, then enter ACTIVE.
REQ-021 SHALL ignore load while in LOAD, and SHALL NOT change the latched level.
REQ-022 SHALL assert obstacle_region one cycle after pixel_x/pixel_y present, when all hold:
- en = 1 and state = ACTIVE;
- some slot with valid = 1 satisfies x <= pixel_x < x+CELL_W and y <= pixel_y < y+CELL_H.
REQ-023 SHALL set crashed in the cycle after a head_valid pulse when all hold:
- en = 1 and state = ACTIVE;
- the head origin equals the origin of a valid slot.
REQ-024 SHALL keep crashed high until one of: crash_clr, load accepted, or reset.
REQ-025 SHALL give set priority when head_valid sets crashed in the same cycle as crash_clr.
REQ-026 SHALL ignore head_valid and move_tick in IDLE and LOAD.
REQ-027 SHALL compute all coordinate comparisons at 11 bits, so x+CELL_W cannot overflow.

Reset
REQ-028 SHALL, on reset:
- enter IDLE, clear all slot valid bits, clear the latched level;
- drive obstacle_region = 0, crashed = 0, busy = 0.
REQ-029 SHALL abort a load when reset is asserted mid-load, and SHALL hold no partial level afterwards.

Configuration
REQ-030 SHALL, with OBSTACLE_MOVE_EN defined, respond to move_tick in ACTIVE:
- every slot with move = 1 sets col = col+1;
- col wraps from 31 to 0;
- when move_tick and head_valid coincide, the collision check uses the pre-move positions.
REQ-031 SHALL, without OBSTACLE_MOVE_EN:
- ignore move_tick;
- not synthesise the move bits, which read as 0.

Structure
REQ-032 SHALL place in shared package obstacle_pkg:
- the FSM state typedef;
- the slot struct (col, row, valid, move);
- GRID_COLS = 32 and GRID_ROWS = 24.
REQ-033 SHALL put the level table in one sub-module, obstacle_level_rom: combinational, addressed by {level, slot}.
REQ-034 SHALL define ROM level 0 as valid slots at rows 5 and 19, cols 11..18, all with move = 0.

Verification
REQ-035 SHALL cover: reset, load level 0 -> busy high for 16 cycles, then ACTIVE; pixel (221,81) -> region = 1 one cycle later; pixel (220,81) -> region = 0.
REQ-036 SHALL cover: pixel (380,96) -> 1; pixel (381,96) -> 0; pixel (361,305) -> 1; pixel (361,321) -> 0.
REQ-037 SHALL cover: head (281,305) with head_valid -> crashed = 1 the next cycle; head (281,289) -> crashed stays 0; crash_clr -> crashed = 0.
REQ-038 SHALL cover: crash_clr and a colliding head_valid in the same cycle -> crashed = 1.
REQ-039 SHALL cover: load pulse at cycle 5 of a load -> ignored, busy drops after cycle 16; reset at cycle 8 -> region = 0 and state IDLE.
REQ-040 SHALL cover, with OBSTACLE_MOVE_EN: a moving slot at col 31 receives move_tick -> col 0, and region appears at x = 1.
